// File: rtl/alu_issue_station.sv
// Reservation station and single-issue scheduler feeding the integer ALU.
// Buffers dispatched micro-ops, wakes pending operands from the CDB, and issues the lowest ready entry.
module alu_issue_station #(
    parameter int DEPTH  = 8,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              disp_valid,
    input  logic [OP_W-1:0]   disp_op,
    input  logic              disp_qj_busy,
    input  logic              disp_qk_busy,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic [TAG_W-1:0]  disp_rob,
    output logic              rs_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_rob,
    input  logic [DATA_W-1:0] cdb_val,
    output logic              alu_status,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [TAG_W-1:0]  alu_rob
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  qjBusy_q, qjBusy_d;
    logic [DEPTH-1:0]  qkBusy_q, qkBusy_d;
    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [OP_W-1:0]   op_d  [DEPTH];
    logic [DATA_W-1:0] vj_q  [DEPTH];
    logic [DATA_W-1:0] vj_d  [DEPTH];
    logic [DATA_W-1:0] vk_q  [DEPTH];
    logic [DATA_W-1:0] vk_d  [DEPTH];
    logic [TAG_W-1:0]  qj_q  [DEPTH];
    logic [TAG_W-1:0]  qj_d  [DEPTH];
    logic [TAG_W-1:0]  qk_q  [DEPTH];
    logic [TAG_W-1:0]  qk_d  [DEPTH];
    logic [TAG_W-1:0]  rob_q [DEPTH];
    logic [TAG_W-1:0]  rob_d [DEPTH];

    logic              status_q, status_d;
    logic [OP_W-1:0]   aluOp_q, aluOp_d;
    logic [DATA_W-1:0] aluRs1_q, aluRs1_d;
    logic [DATA_W-1:0] aluRs2_q, aluRs2_d;
    logic [TAG_W-1:0]  aluRob_q, aluRob_d;

    logic [DEPTH-1:0]  ready;
    logic              issueHit;
    logic [IDX_W-1:0]  issueIdx;
    logic              freeHit;
    logic [IDX_W-1:0]  freeIdx;
    logic              dispJHit;
    logic              dispKHit;

    assign rs_full    = &busy_q;
    assign alu_status = status_q;
    assign alu_op     = aluOp_q;
    assign alu_rs1    = aluRs1_q;
    assign alu_rs2    = aluRs2_q;
    assign alu_rob    = aluRob_q;

    // Priority encoders: descending loops leave the lowest matching index selected.
    always_comb begin
        ready    = busy_q & ~qjBusy_q & ~qkBusy_q;
        issueHit = 1'b0;
        issueIdx = '0;
        freeHit  = 1'b0;
        freeIdx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issueHit = 1'b1;
                issueIdx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                freeHit = 1'b1;
                freeIdx = IDX_W'(i);
            end
        end
        dispJHit = cdb_valid && disp_qj_busy && (cdb_rob == disp_qj);
        dispKHit = cdb_valid && disp_qk_busy && (cdb_rob == disp_qk);
    end

    always_comb begin
        busy_d   = busy_q;
        qjBusy_d = qjBusy_q;
        qkBusy_d = qkBusy_q;
        op_d     = op_q;
        vj_d     = vj_q;
        vk_d     = vk_q;
        qj_d     = qj_q;
        qk_d     = qk_q;
        rob_d    = rob_q;
        status_d = 1'b0;
        aluOp_d  = aluOp_q;
        aluRs1_d = aluRs1_q;
        aluRs2_d = aluRs2_q;
        aluRob_d = aluRob_q;

        if (clear) begin
            busy_d = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && cdb_valid) begin
                    if (qjBusy_q[i] && (qj_q[i] == cdb_rob)) begin
                        vj_d[i]     = cdb_val;
                        qjBusy_d[i] = 1'b0;
                    end
                    if (qkBusy_q[i] && (qk_q[i] == cdb_rob)) begin
                        vk_d[i]     = cdb_val;
                        qkBusy_d[i] = 1'b0;
                    end
                end
            end

            if (issueHit) begin
                busy_d[issueIdx] = 1'b0;
                status_d         = 1'b1;
                aluOp_d          = op_q[issueIdx];
                aluRs1_d         = vj_q[issueIdx];
                aluRs2_d         = vk_q[issueIdx];
                aluRob_d         = rob_q[issueIdx];
            end

            // The free slot is never the issuing one, since it comes from the pre-issue busy vector.
            if (disp_valid && freeHit) begin
                busy_d[freeIdx]   = 1'b1;
                op_d[freeIdx]     = disp_op;
                rob_d[freeIdx]    = disp_rob;
                qj_d[freeIdx]     = disp_qj;
                qk_d[freeIdx]     = disp_qk;
                qjBusy_d[freeIdx] = disp_qj_busy && !dispJHit;
                qkBusy_d[freeIdx] = disp_qk_busy && !dispKHit;
                vj_d[freeIdx]     = dispJHit ? cdb_val : disp_vj;
                vk_d[freeIdx]     = dispKHit ? cdb_val : disp_vk;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q   <= '0;
            qjBusy_q <= '0;
            qkBusy_q <= '0;
            status_q <= 1'b0;
            aluOp_q  <= '0;
            aluRs1_q <= '0;
            aluRs2_q <= '0;
            aluRob_q <= '0;
        end else begin
            busy_q   <= busy_d;
            qjBusy_q <= qjBusy_d;
            qkBusy_q <= qkBusy_d;
            status_q <= status_d;
            aluOp_q  <= aluOp_d;
            aluRs1_q <= aluRs1_d;
            aluRs2_q <= aluRs2_d;
            aluRob_q <= aluRob_d;
        end
        op_q  <= op_d;
        vj_q  <= vj_d;
        vk_q  <= vk_d;
        qj_q  <= qj_d;
        qk_q  <= qk_d;
        rob_q <= rob_d;
    end

endmodule
